// File: rtl/truth_table_sweeper.sv
// Sweeps input codes 0..15 onto a 4-in/10-out logic block and captures each result into a 16-row table.
// Optional feature: define TTS_SIGNATURE_EN to build the rotate-xor result signature on sig.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  code_out,
  input  logic [9:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] row_valid,
  input  logic [3:0]  rd_addr,
  output logic [9:0]  rd_data,
  output logic [9:0]  sig
);

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE_ST
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  code_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] row_valid_q;
  logic [9:0]  rd_data_q;
  logic [9:0]  table_q [16];
  logic        wr_en;
  logic        accept;

  assign wr_en  = (state_q == CAPTURE);
  assign accept = (state_q == IDLE) && start;

  // Table storage carries no reset so it maps onto plain RAM; row_valid qualifies rows.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_q[code_q] <= f_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_valid_q <= '0;
      rd_data_q   <= '0;
    end else begin
      // Read-before-write: a read of the row being captured returns its old contents.
      rd_data_q <= table_q[rd_addr];
      case (state_q)
        IDLE: begin
          if (start) begin
            code_q      <= '0;
            cnt_q       <= CNT_LOAD;
            row_valid_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == 8'd0) begin
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        CAPTURE: begin
          row_valid_q[code_q] <= 1'b1;
          if (code_q == 4'd15) begin
            done_q  <= 1'b1;
            state_q <= DONE_ST;
          end else begin
            code_q  <= code_q + 4'd1;
            cnt_q   <= CNT_LOAD;
            state_q <= SETTLE;
          end
        end
        DONE_ST: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef TTS_SIGNATURE_EN
  logic [9:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= '0;
    end else if (wr_en) begin
      sig_q <= {sig_q[8:0], sig_q[9]} ^ f_in;
    end
  end

  assign sig = sig_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign sig = 10'h000;
`endif

  assign code_out  = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign row_valid = row_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (settle 3 and settle 0) driven by a lookup-table breadboard model.
module tb_truth_table_sweeper;

  localparam int S0 = 3;
  localparam int S1 = 0;

  typedef struct packed {
    logic [15:0][9:0] tbl;
    logic [9:0]       sig;
    logic [31:0]      lat;
    logic [31:0]      acc;
  } sweep_t;

  typedef struct packed {
    logic [31:0] due;
    logic [9:0]  exp;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic [3:0]  code_out [2];
  logic [9:0]  f_in [2];
  logic        busy [2];
  logic        done [2];
  logic [15:0] row_valid [2];
  logic [3:0]  rd_addr [2];
  logic [9:0]  rd_data [2];
  logic [9:0]  sig [2];

  logic [9:0]       lut [2][16];
  logic [15:0][9:0] last_tbl [2];
  bit               known [2];
  bit               done_seen [2];
  bit               done_prev [2];
  bit               busy_prev [2];
  logic [3:0]       code_prev [2];
  int               done_cyc [2];

  sweep_t sq0[$], sq1[$];
  rd_t    rq0[$], rq1[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Breadboard stand-in: the block's response is a per-sweep lookup on the applied code.
  assign f_in[0] = lut[0][code_out[0]];
  assign f_in[1] = lut[1][code_out[1]];

  truth_table_sweeper #(.SETTLE_CYCLES(S0)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .code_out(code_out[0]), .f_in(f_in[0]),
    .busy(busy[0]), .done(done[0]), .row_valid(row_valid[0]), .rd_addr(rd_addr[0]),
    .rd_data(rd_data[0]), .sig(sig[0])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(S1)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .code_out(code_out[1]), .f_in(f_in[1]),
    .busy(busy[1]), .done(done[1]), .row_valid(row_valid[1]), .rd_addr(rd_addr[1]),
    .rd_data(rd_data[1]), .sig(sig[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc %0d: got %0h, expected %0h", name, d, cyc, act, exp);
    end
  endtask

  // Signature as a whole: each row is rotated left once per later capture, then all rows are xored.
  function automatic logic [9:0] sig_model(input logic [15:0][9:0] t);
`ifdef TTS_SIGNATURE_EN
    logic [9:0]  s;
    logic [19:0] w;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      w = {t[k], t[k]} << ((15 - k) % 10);
      s ^= w[19:10];
    end
    return s;
`else
    return 10'h000;
`endif
  endfunction

  task automatic push_sweep(input int d, input sweep_t r);
    if (d == 0) sq0.push_back(r);
    else        sq1.push_back(r);
  endtask

  task automatic push_rd(input int d, input int due, input logic [9:0] exp);
    rd_t e;
    e.due = due;
    e.exp = exp;
    if (d == 0) rq0.push_back(e);
    else        rq1.push_back(e);
  endtask

  task automatic mon(input int d);
    sweep_t r;
    rd_t    e;
    bit     have;
    if (done[d]) begin
      chk("done_width", d, {31'b0, done_prev[d]}, 32'd0);
      have = 1'b0;
      if (d == 0 && sq0.size() > 0) begin r = sq0.pop_front(); have = 1'b1; end
      if (d == 1 && sq1.size() > 0) begin r = sq1.pop_front(); have = 1'b1; end
      if (!have) begin
        chk("unexpected_done", d, 32'd1, 32'd0);
      end else begin
        chk("done_latency", d, cyc - r.acc + 1, r.lat);
        chk("row_valid", d, {16'b0, row_valid[d]}, 32'h0000_FFFF);
        chk("sig", d, {22'b0, sig[d]}, {22'b0, r.sig});
        chk("code_at_done", d, {28'b0, code_out[d]}, 32'd15);
        chk("busy_at_done", d, {31'b0, busy[d]}, 32'd1);
      end
      done_seen[d] = 1'b1;
      done_cyc[d]  = cyc;
    end
    forever begin
      have = 1'b0;
      if (d == 0 && rq0.size() > 0 && rq0[0].due == cyc) begin e = rq0.pop_front(); have = 1'b1; end
      if (d == 1 && rq1.size() > 0 && rq1[0].due == cyc) begin e = rq1.pop_front(); have = 1'b1; end
      if (!have) break;
      chk("rd_data", d, {22'b0, rd_data[d]}, {22'b0, e.exp});
    end
    if (busy[d] && busy_prev[d]) begin
      chk("code_monotonic", d, {31'b0, (code_out[d] < code_prev[d])}, 32'd0);
    end
    done_prev[d] = done[d];
    busy_prev[d] = busy[d];
    code_prev[d] = code_out[d];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_done(input int d);
    for (int i = 0; i < 400 && !done_seen[d]; i++) @(negedge clk);
    if (!done_seen[d]) chk("done_timeout", d, 32'd0, 32'd1);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // mode: 0 identity, 1 random, 2 constant 1, 3 constant 0
  task automatic do_sweep(input int d, input int mode, input bit rbw, input bit ignore,
                          input bit abort, input bit hold);
    sweep_t           r;
    logic [15:0][9:0] old;
    int               s, acc, off, a;
    s   = (d == 0) ? S0 : S1;
    old = last_tbl[d];
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0:       lut[d][k] = 10'(k);
        1:       lut[d][k] = 10'($urandom);
        2:       lut[d][k] = 10'h001;
        default: lut[d][k] = 10'h000;
      endcase
      r.tbl[k] = lut[d][k];
    end
    acc   = cyc + 1;
    r.sig = sig_model(r.tbl);
    r.lat = 16 * (s + 2) + 1;
    r.acc = acc;
    push_sweep(d, r);
    done_seen[d] = 1'b0;
    start[d] = 1'b1;
    if (rbw && known[d]) begin
      rd_addr[d] = 4'd7;
      for (int t = 1; t <= 45; t++)
        push_rd(d, acc + t, (t <= 8 * (s + 2)) ? old[7] : r.tbl[7]);
    end
    @(negedge clk);
    if (!hold) start[d] = 1'b0;
    if (abort) begin
      wait_until(acc + 6 * (s + 2) + 2);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", d, {31'b0, busy[d]}, 32'd0);
      chk("abort_code", d, {28'b0, code_out[d]}, 32'd0);
      chk("abort_row_valid", d, {16'b0, row_valid[d]}, 32'd0);
      chk("abort_done", d, {31'b0, done[d]}, 32'd0);
      chk("abort_sig", d, {22'b0, sig[d]}, 32'd0);
      if (d == 0) void'(sq0.pop_back());
      else        void'(sq1.pop_back());
      known[d] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    if (ignore) begin
      wait_until(acc + 9);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      wait_until(acc + 49);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
    end
    wait_done(d);
    if (hold) begin
      r.acc = done_cyc[d] + 2;
      push_sweep(d, r);
      done_seen[d] = 1'b0;
      wait_until(done_cyc[d] + 2);
      start[d] = 1'b0;
      wait_done(d);
    end
    repeat (5) @(negedge clk);
    chk("no_restart", d, {31'b0, busy[d]}, 32'd0);
    last_tbl[d] = r.tbl;
    known[d]    = 1'b1;
    off = $urandom_range(15);
    for (int i = 0; i < 16; i++) begin
      a = (off + i) % 16;
      rd_addr[d] = 4'(a);
      push_rd(d, cyc + 1, r.tbl[a]);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d]   = 1'b0;
      rd_addr[d] = 4'd0;
      known[d]   = 1'b0;
      last_tbl[d] = '0;
      for (int k = 0; k < 16; k++) lut[d][k] = 10'h000;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", d, {31'b0, busy[d]}, 32'd0);
      chk("reset_done", d, {31'b0, done[d]}, 32'd0);
      chk("reset_code", d, {28'b0, code_out[d]}, 32'd0);
      chk("reset_row_valid", d, {16'b0, row_valid[d]}, 32'd0);
      chk("reset_rd_data", d, {22'b0, rd_data[d]}, 32'd0);
      chk("reset_sig", d, {22'b0, sig[d]}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_sweep(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_sweep(0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_sweep(0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    do_sweep(0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_sweep(0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_sweep(0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_sweep(0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_sweep(1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_sweep(1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_sweep(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    if (sq0.size() != 0 || sq1.size() != 0) chk("sweeps_outstanding", 0, sq0.size() + sq1.size(), 32'd0);
    if (rq0.size() != 0 || rq1.size() != 0) chk("reads_outstanding", 0, rq0.size() + rq1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
